bcd_serial_add_ctrl: RTL and testbench
======================================

// Module: bcd_serial_add_ctrl
// PURPOSE
//  Sequencer for a shared single-digit BCD adder datapath: on a start request it adds two
//  DIGITS-wide BCD operands one digit per cycle, rippling carry LSD->MSD. Input digits >9
//  clamp to 9. It commits the result and drives a time-multiplexed seven-segment display
//  (DIGITS+1 positions, carry digit on top). Sits between switch/operand logic and display pins.
// PARAMETERS
//  DIGITS    4   number of BCD operand digits (>=1)
//  SCAN_DIV  16  clk cycles each display position stays lit (>=2)
// PORTS
//  clk        in   1             system clock, all state on rising edge
//  rst_n      in   1             asynchronous active-low reset
//  start      in   1             request; sampled only in IDLE
//  op_a       in   4*DIGITS      BCD operand A, digit i = op_a[4i+3:4i]
//  op_b       in   4*DIGITS      BCD operand B
//  carry_in   in   1             carry into digit 0
//  busy       out  1             high from cycle after accepted start until DONE is left
//  done       out  1             one-cycle pulse, result committed
//  sum        out  4*(DIGITS+1)  committed BCD result; top digit is 0 or 1
//  carry_out  out  1             committed carry from MSD (== sum top digit)
//  clamped    out  1             committed flag: any operand digit was >9
//  seg        out  7             segments {g..a}, active-low (0 = 7'b1000000)
//  an         out  DIGITS+1      position enables, active-low one-hot
// BEHAVIOUR
//  Reset (async): FSM=IDLE, idx=0, busy=0, done=0, sum=0, carry_out=0, clamped=0,
//   scan counter=0, scan position=0, an=~1, seg=7'b1000000.
//  FSM IDLE: start=1 -> latch op_a, op_b, carry_in into working regs; clear work carry/clamp;
//   idx=0; go ADD. ADD: per cycle on digit idx: a'=min(a,9), b'=min(b,9), s=a'+b'+c (5 bits).
//   s>9 -> digit=s-10, c=1; else digit=s, c=0. clamp flag ORs (a>9)|(b>9). idx==DIGITS-1 -> DONE.
//   DONE: one cycle; sum={3'b0,c,work digits}, carry_out=c, clamped=flag, done=1; go IDLE.
//  Latency: start sampled at edge 0 -> done high after edge DIGITS+1 (DIGITS=4: 5 cycles).
//  sum/carry_out/clamped change only in DONE; hold across later requests until next commit.
//  start while not IDLE: ignored, not queued. start held high: new op begins from IDLE after
//   DONE (back-to-back period DIGITS+2 cycles).
//  Operands sampled only at acceptance; changes during ADD have no effect.
//  Reset mid-operation: abort immediately, all outputs to reset values, no done pulse.
//  Display scanner: free-running, independent of FSM. Counter 0..SCAN_DIV-1; at wrap
//   position advances 0..DIGITS then wraps to 0. an[p]=0 only for current position p.
//   seg = decode(sum digit p): 0..9 standard active-low patterns; 10..15 -> 7'b1111111.
//  Display shows committed sum only, never working digits.
// CONFIGURATION
//  BCD_LZ_BLANK_EN defined: positions above the most significant nonzero sum digit show
//   seg=7'b1111111 (an still scans); position 0 always displayed, so sum=0 shows "0".
//  Not defined: every position decoded, leading zeros shown as 7'b1000000.
// TESTING (DIGITS=4, SCAN_DIV=16)
//  Reset asserted mid-ADD -> busy=0, done=0, sum=0, an=5'b11110, seg=7'b1000000; next start completes normally.
//  op_a=16'h1234, op_b=16'h5678, cin=0, start 1 cycle -> done after 5 cycles, sum=20'h06912, carry_out=0, clamped=0.
//  op_a=16'h9999, op_b=16'h0001, cin=0 -> sum=20'h10000, carry_out=1; with cin=1 -> sum=20'h10001.
//  op_a=16'h00AF, op_b=16'h0000, cin=1 -> digits clamp to 0099+1, sum=20'h00100, clamped=1.
//  start pulsed again at cycles 1..4 of an op -> ignored, exactly one done, result of first op.
//  sum=20'h06912 -> an steps 11110,11101,..,01111 every 16 cycles, seg 2,1,9,6,0 patterns;
//   BCD_LZ_BLANK_EN -> position 4 seg=7'b1111111.

Source files
------------

// File: rtl/bcd_serial_add_ctrl_if.sv
// Handshake and display bundle for the serial BCD adder sequencer.
// master: operand/switch side (drives start and operands, sees results and pins).
// slave : the sequencer itself.
interface bcd_serial_add_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic                    start;
    logic [4*DIGITS-1:0]     op_a;
    logic [4*DIGITS-1:0]     op_b;
    logic                    carry_in;
    logic                    busy;
    logic                    done;
    logic [4*(DIGITS+1)-1:0] sum;
    logic                    carry_out;
    logic                    clamped;
    logic [6:0]              seg;
    logic [DIGITS:0]         an;

    modport master (
        output start, op_a, op_b, carry_in,
        input  busy, done, sum, carry_out, clamped, seg, an
    );

    modport slave (
        input  start, op_a, op_b, carry_in,
        output busy, done, sum, carry_out, clamped, seg, an
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Sequencer for a shared single-digit BCD adder: adds two DIGITS-wide BCD operands one digit
// per cycle (LSD first), commits the result and scans it onto a multiplexed 7-segment display
// with DIGITS+1 positions (carry digit on top).
// Optional feature: define BCD_LZ_BLANK_EN to blank leading-zero positions (position 0 is
// always shown).
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_serial_add_ctrl_if.slave bus
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PW = $clog2(DIGITS + 1);
    localparam int unsigned CW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;

    // Working registers: operands shift right one digit per ADD cycle, result shifts in at top.
    logic [W-1:0]        r_op_a;
    logic [W-1:0]        r_op_b;
    logic [W-1:0]        r_work;
    logic [IW-1:0]       r_idx;
    logic                r_carry;
    logic                r_clamp;

    // Committed results.
    logic [W+3:0]        r_sum;
    logic                r_carry_out;
    logic                r_clamped;
    logic                r_done;

    // Display scanner.
    logic [CW-1:0]       r_scan_cnt;
    logic [PW-1:0]       r_pos;

    logic [3:0]          w_a_raw;
    logic [3:0]          w_b_raw;
    logic [3:0]          w_a_cl;
    logic [3:0]          w_b_cl;
    logic                w_a_big;
    logic                w_b_big;
    logic [4:0]          w_sum5;
    logic                w_dig_carry;
    logic [3:0]          w_digit;
    logic [W+3:0]        w_work_cat;

    logic [3:0]          w_disp_digit;
    logic                w_blank;
    logic [DIGITS:0]     w_an;
    logic [6:0]          w_seg;

    // Active-low {g..a} patterns; non-decimal codes are blanked.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: start only sampled in IDLE, so requests during ADD/DONE are dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: if (bus.start) w_state_nxt = StAdd;
            StAdd:  if (r_idx == IW'(DIGITS - 1)) w_state_nxt = StDone;
            StDone: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Single-digit BCD add on the current least significant working digit.
    always_comb begin
        w_a_raw     = r_op_a[3:0];
        w_b_raw     = r_op_b[3:0];
        w_a_big     = (w_a_raw > 4'd9);
        w_b_big     = (w_b_raw > 4'd9);
        w_a_cl      = w_a_big ? 4'd9 : w_a_raw;
        w_b_cl      = w_b_big ? 4'd9 : w_b_raw;
        w_sum5      = {1'b0, w_a_cl} + {1'b0, w_b_cl} + {4'b0, r_carry};
        w_dig_carry = (w_sum5 > 5'd9);
        w_digit     = w_dig_carry ? 4'(w_sum5 - 5'd10) : w_sum5[3:0];
        w_work_cat  = {w_digit, r_work};
    end

    // Datapath: latch on accept, accumulate digits in ADD, commit in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_work      <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_clamp     <= 1'b0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_clamped   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_op_a  <= bus.op_a;
                        r_op_b  <= bus.op_b;
                        r_carry <= bus.carry_in;
                        r_clamp <= 1'b0;
                        r_idx   <= '0;
                    end
                end
                StAdd: begin
                    r_op_a  <= r_op_a >> 4;
                    r_op_b  <= r_op_b >> 4;
                    r_work  <= w_work_cat[W+3:4];
                    r_carry <= w_dig_carry;
                    r_clamp <= r_clamp | w_a_big | w_b_big;
                    r_idx   <= r_idx + IW'(1);
                end
                StDone: begin
                    r_sum       <= {3'b000, r_carry, r_work};
                    r_carry_out <= r_carry;
                    r_clamped   <= r_clamp;
                    r_done      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Free-running scan: each position lit for SCAN_DIV cycles, positions 0..DIGITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_pos      <= '0;
        end else if (r_scan_cnt == CW'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_pos      <= (r_pos == PW'(DIGITS)) ? '0 : r_pos + PW'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + CW'(1);
        end
    end

    // Display mux: select committed digit for the current position and drive the anodes.
    always_comb begin
        w_disp_digit = 4'd0;
        w_an         = '1;
        for (int p = 0; p <= int'(DIGITS); p++) begin
            if (r_pos == PW'(p)) begin
                w_disp_digit = r_sum[4*p +: 4];
                w_an[p]      = 1'b0;
            end
        end
    end

`ifdef BCD_LZ_BLANK_EN
    logic [PW-1:0] w_msnz;

    // Highest nonzero digit position; positions above it are leading zeros.
    always_comb begin
        w_msnz = '0;
        for (int p = 1; p <= int'(DIGITS); p++) begin
            if (r_sum[4*p +: 4] != 4'd0) w_msnz = PW'(p);
        end
        w_blank = (r_pos > w_msnz);
    end
`else
    // Every position decoded, leading zeros included.
    always_comb begin
        w_blank = 1'b0;
    end
`endif

    // Segment output.
    always_comb begin
        w_seg = w_blank ? 7'b1111111 : seg_decode(w_disp_digit);
    end

    assign bus.busy      = (r_state != StIdle);
    assign bus.done      = r_done;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry_out;
    assign bus.clamped   = r_clamped;
    assign bus.seg       = w_seg;
    assign bus.an        = w_an;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (DIGITS=4, SCAN_DIV=16).
module tb_bcd_serial_add_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   m_n;     // posedges since reset release, drives the scanner model

    bcd_serial_add_ctrl_if #(.DIGITS(4)) bus ();

    bcd_serial_add_ctrl #(
        .DIGITS   (4),
        .SCAN_DIV (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_n <= 0;
        else        m_n <= m_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle, wait for done, return cycles from accepting edge to done.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          output int cyc);
        @(negedge clk);
        bus.op_a = a; bus.op_b = b; bus.carry_in = cin; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 30) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] t [10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    initial begin
        int          cyc;
        int          ndone;
        int          t1;
        int          t2;
        int          digs [5];
        logic [4:0]  ea;
        logic [6:0]  es;

        checks = 0; failures = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.carry_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",    32'(bus.busy),      32'd0);
        chk("rst_done",    32'(bus.done),      32'd0);
        chk("rst_sum",     32'(bus.sum),       32'h0);
        chk("rst_cout",    32'(bus.carry_out), 32'd0);
        chk("rst_clamped", 32'(bus.clamped),   32'd0);
        chk("rst_an",      32'(bus.an),        32'b11110);
        chk("rst_seg",     32'(bus.seg),       32'h40);
        rst_n = 1'b1;

        // Basic add, latency and busy.
        @(negedge clk);
        bus.op_a = 16'h1234; bus.op_b = 16'h5678; bus.carry_in = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_accept", 32'(bus.busy), 32'd1);
        cyc = 0;
        while (!bus.done && cyc < 30) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        chk("latency",    32'(cyc),            32'd5);
        chk("sum_6912",   32'(bus.sum),        32'h06912);
        chk("cout_6912",  32'(bus.carry_out),  32'd0);
        chk("clamp_6912", 32'(bus.clamped),    32'd0);
        chk("busy_at_done", 32'(bus.busy),     32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(bus.done),       32'd0);

        run_op(16'h9999, 16'h0001, 1'b0, cyc);
        chk("sum_10000",  32'(bus.sum),        32'h10000);
        chk("cout_10000", 32'(bus.carry_out),  32'd1);
        run_op(16'h9999, 16'h0001, 1'b1, cyc);
        chk("sum_10001",  32'(bus.sum),        32'h10001);
        run_op(16'h00AF, 16'h0000, 1'b1, cyc);
        chk("sum_clamp",  32'(bus.sum),        32'h00100);
        chk("clamped",    32'(bus.clamped),    32'd1);
        chk("cout_clamp", 32'(bus.carry_out),  32'd0);

        // Start pulses during ADD are dropped.
        @(negedge clk);
        bus.op_a = 16'h0001; bus.op_b = 16'h0002; bus.carry_in = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'b1; bus.op_a = 16'h5555; bus.op_b = 16'h5555;
            @(posedge clk);
        end
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) ndone++;
            @(posedge clk); @(negedge clk);
        end
        chk("ignore_ndone", 32'(ndone),   32'd1);
        chk("ignore_sum",   32'(bus.sum), 32'h00003);
        chk("ignore_idle",  32'(bus.busy), 32'd0);

        // Held start: back-to-back period DIGITS+2.
        @(negedge clk);
        bus.op_a = 16'h0011; bus.op_b = 16'h0022; bus.start = 1'b1;
        cyc = 0; t1 = 0; t2 = 0;
        while (t2 == 0 && cyc < 40) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (bus.done) begin
                if (t1 == 0) t1 = cyc;
                else         t2 = cyc;
            end
        end
        bus.start = 1'b0;
        chk("b2b_first",  32'(t1),       32'd6);
        chk("b2b_period", 32'(t2 - t1),  32'd6);
        chk("b2b_sum",    32'(bus.sum),  32'h00033);

        // Operands changed during ADD have no effect.
        @(negedge clk);
        bus.op_a = 16'h1111; bus.op_b = 16'h2222; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.op_a = 16'h9999; bus.op_b = 16'h9999; bus.carry_in = 1'b1;
        cyc = 0;
        while (!bus.done && cyc < 30) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        chk("late_op_sum", 32'(bus.sum), 32'h03333);
        bus.carry_in = 1'b0;

        // Reset in the middle of ADD.
        @(negedge clk);
        bus.op_a = 16'h1111; bus.op_b = 16'h1111; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_sum",  32'(bus.sum),  32'h0);
        chk("midrst_an",   32'(bus.an),   32'b11110);
        chk("midrst_seg",  32'(bus.seg),  32'h40);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("midrst_nodone", 32'(ndone), 32'd0);

        run_op(16'h1234, 16'h5678, 1'b0, cyc);
        chk("post_rst_lat", 32'(cyc),     32'd5);
        chk("post_rst_sum", 32'(bus.sum), 32'h06912);

        // Display scan of 06912: positions 0..4 show 2,1,9,6,0.
        digs = '{2, 1, 9, 6, 0};
        for (int p = 0; p < 5; p++) begin
            cyc = 0;
            while (((m_n / 16) % 5) != p && cyc < 200) begin
                @(posedge clk); cyc++; @(negedge clk);
            end
            chk("scan_wait", 32'(cyc < 200), 32'd1);
            ea = 5'b11111;
            ea[p] = 1'b0;
            es = seg_of(digs[p]);
`ifdef BCD_LZ_BLANK_EN
            if (p == 4) es = 7'b1111111;
`endif
            chk($sformatf("scan_an_p%0d", p),  32'(bus.an),  32'(ea));
            chk($sformatf("scan_seg_p%0d", p), 32'(bus.seg), 32'(es));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
